// File: rtl/fft_mag_capture.sv
`default_nettype none
// ============================================================================
// Module      : fft_mag_capture
// Description : Approximate per-bin FFT magnitude, max(|re|,|im|) + min/2,
//               captured one frame per arm edge and read back by bin index.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_mag_capture #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              sink_valid,
    output logic              sink_ready,
    input  logic              sink_sop,
    input  logic              sink_eop,
    input  logic [DATA_W-1:0] sink_real,
    input  logic [DATA_W-1:0] sink_imag,
    input  logic [ADDR_W-1:0] rd_index,
    output logic [15:0]       rd_data,
    output logic              done,
    output logic              frame_err,
    output logic [ADDR_W:0]   bin_count
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-2:0] MAX_POS   = {(DATA_W-1){1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                arm_q;
    logic                sink_ready_q;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic [ADDR_W:0]     bin_count_q, bin_count_d;
    logic                frame_err_q, frame_err_d;
    logic                drain_cnt_q, drain_cnt_d;

    logic                s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
    logic [DATA_W-2:0]   abs_re_q, abs_re_d;
    logic [DATA_W-2:0]   abs_im_q, abs_im_d;
    logic                s2_valid_q, s2_valid_d;
    logic [ADDR_W-1:0]   s2_addr_q, s2_addr_d;
    logic [15:0]         mag_q, mag_d;
    logic [15:0]         rd_data_q, rd_data_d;

    logic                arm_edge;
    logic                accept;
    logic                push;
    logic [ADDR_W-1:0]   push_addr;
    logic [DATA_W-2:0]   mag_max, mag_min;
    logic [DATA_W:0]     mag_sum;
    logic [31:0]         mag_sum_ext;

    logic [15:0]         mem [DEPTH];

    // The most-negative code has no positive twin; clamp it to full scale.
    function automatic logic [DATA_W-2:0] sat_abs(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] neg;
        neg = -x;
        if (x == MOST_NEG)
            sat_abs = MAX_POS;
        else if (x[DATA_W-1])
            sat_abs = neg[DATA_W-2:0];
        else
            sat_abs = x[DATA_W-2:0];
    endfunction

    assign arm_edge = arm & ~arm_q;
    assign accept   = sink_valid & sink_ready_q;

    always_comb begin
        state_d     = state_q;
        wa_d        = wa_q;
        bin_count_d = bin_count_q;
        frame_err_d = frame_err_q;
        drain_cnt_d = drain_cnt_q;
        push        = 1'b0;
        push_addr   = wa_q;
        if (arm_edge) begin
            state_d     = S_ARMED;
            wa_d        = '0;
            bin_count_d = '0;
            frame_err_d = 1'b0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (accept && sink_sop) begin
                        push        = 1'b1;
                        push_addr   = '0;
                        wa_d        = ADDR_ONE;
                        bin_count_d = CNT_ONE;
                        drain_cnt_d = 1'b0;
                        state_d     = sink_eop ? S_DRAIN : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (accept) begin
                        push = 1'b1;
                        if (sink_sop) begin
                            // Unexpected restart: flag it and rebuild from bin 0.
                            frame_err_d = 1'b1;
                            push_addr   = '0;
                            wa_d        = ADDR_ONE;
                            bin_count_d = CNT_ONE;
                        end else begin
                            wa_d        = wa_q + ADDR_ONE;
                            bin_count_d = bin_count_q + CNT_ONE;
                        end
                        if (sink_eop) begin
                            state_d     = S_DRAIN;
                            drain_cnt_d = 1'b0;
                        end else if (!sink_sop && wa_q == LAST_ADDR) begin
                            frame_err_d = 1'b1;
                            state_d     = S_DRAIN;
                            drain_cnt_d = 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q)
                        state_d = S_DONE;
                    else
                        drain_cnt_d = 1'b1;
                end
                S_IDLE, S_DONE: begin
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        s1_valid_d  = push;
        s1_addr_d   = push_addr;
        abs_re_d    = sat_abs(sink_real);
        abs_im_d    = sat_abs(sink_imag);

        mag_max     = (abs_re_q >= abs_im_q) ? abs_re_q : abs_im_q;
        mag_min     = (abs_re_q >= abs_im_q) ? abs_im_q : abs_re_q;
        mag_sum     = {2'b00, mag_max} + ({2'b00, mag_min} >> 1);
        mag_sum_ext = 32'(mag_sum);
        mag_d       = (mag_sum_ext > 32'h0000_FFFF) ? 16'hFFFF : mag_sum_ext[15:0];
        s2_valid_d  = s1_valid_q & ~arm_edge;
        s2_addr_d   = s1_addr_q;

        rd_data_d   = mem[rd_index];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            arm_q        <= 1'b0;
            sink_ready_q <= 1'b0;
            wa_q         <= '0;
            bin_count_q  <= '0;
            frame_err_q  <= 1'b0;
            drain_cnt_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            abs_re_q     <= '0;
            abs_im_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_addr_q    <= '0;
            mag_q        <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            arm_q        <= arm;
            sink_ready_q <= 1'b1;
            wa_q         <= wa_d;
            bin_count_q  <= bin_count_d;
            frame_err_q  <= frame_err_d;
            drain_cnt_q  <= drain_cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            abs_re_q     <= abs_re_d;
            abs_im_q     <= abs_im_d;
            s2_valid_q   <= s2_valid_d;
            s2_addr_q    <= s2_addr_d;
            mag_q        <= mag_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Buffer contents survive reset; a read of the address being written sees the old word.
    always_ff @(posedge clk) begin
        if (s2_valid_q)
            mem[s2_addr_q] <= mag_q;
    end

    assign sink_ready = sink_ready_q;
    assign rd_data    = rd_data_q;
    assign done       = (state_q == S_DONE);
    assign frame_err  = frame_err_q;
    assign bin_count  = bin_count_q;

endmodule
`default_nettype wire

// File: doc/fft_mag_capture.md
Name: fft_mag_capture

Overview:
- Upstream feeder for the 16-bit input PIO that the Nios CPU reads.
- Consumes the FFT core's Avalon-ST output frame and computes an approximate magnitude per bin: max(|re|,|im|) + min(|re|,|im|)/2.
- Stores one full frame in an internal buffer after software arms it.
- The CPU selects a bin through rd_index, driven by an output PIO, and reads that bin's magnitude back through the input PIO on rd_data.

Parameters:
- DATA_W, 16: signed width of sink_real / sink_imag.
- ADDR_W, 8: buffer address width; frame depth is 2**ADDR_W bins.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- arm  in  1  level from output PIO; a rising edge starts a new capture.
- sink_valid  in  1  FFT beat valid.
- sink_ready  out  1  constant 1 out of reset; the block never backpressures.
- sink_sop  in  1  first bin of frame.
- sink_eop  in  1  last bin of frame.
- sink_real  in  DATA_W  signed real part.
- sink_imag  in  DATA_W  signed imaginary part.
- rd_index  in  ADDR_W  bin to read back.
- rd_data  out  16  magnitude at rd_index; wired to PIO in_port.
- done  out  1  frame captured and pipeline drained.
- frame_err  out  1  sticky error flag for the current capture.
- bin_count  out  ADDR_W+1  number of bins stored in the current capture.

Behaviour:
- Reset values (asynchronous, on reset_n low):
  - state=IDLE, rd_data=0, done=0, frame_err=0, bin_count=0, sink_ready=0.
  - sink_ready goes to 1 on the first clk edge after reset release.
  - Buffer contents are not reset.
- arm edge detect:
  - arm is registered; edge = arm & ~arm_q.
  - An edge in any state: go to ARMED, clear done, frame_err and bin_count, reset write address to 0, flush the pipeline valid bits.
- Magnitude pipeline (accepted beat = sink_valid & sink_ready):
  - Stage 1 registers |re| and |im|; the most-negative input saturates to 2**(DATA_W-1)-1.
  - Stage 2 registers max + (min>>1) in DATA_W+1 bits, then saturates to 16 bits unsigned (0xFFFF).
  - For DATA_W=16 the maximum is 49150, so no saturation occurs.
  - Latency: beat accepted at cycle N is written into the buffer at the edge ending cycle N+2.
- FSM:
  - IDLE: beats accepted and discarded.
  - ARMED: discard beats until valid & sop. That beat is bin 0 and the state moves to CAPTURE. eop without sop is ignored.
  - CAPTURE: every valid beat enters the pipeline at write address wa, then wa++ and bin_count++.
    - valid & eop: that beat is stored, then go to DRAIN.
    - valid & sop while in CAPTURE: set frame_err; the beat restarts the frame at address 0 and bin_count becomes 1.
    - wa reaching 2**ADDR_W-1 on a valid beat without eop: store the beat, set frame_err, go to DRAIN.
  - DRAIN: 2 cycles for the pipeline to finish writing, then go to DONE. Beats arriving in DRAIN are discarded.
  - DONE: done=1; beats discarded until the next arm edge.
- Read port:
  - rd_data <= buffer[rd_index] every cycle, with 1-cycle latency.
  - Read-during-write to the same address returns the old value.
  - Reads during CAPTURE are allowed and return partial or stale data.
- Simultaneous events:
  - An arm edge and a sop beat in the same cycle: the arm wins. State becomes ARMED and the beat is discarded.
  - Reset mid-capture: return to IDLE immediately; partial data is left in the buffer.

Test Plan:
- Reset: hold reset_n low 5 cycles -> rd_data=0, done=0, frame_err=0, bin_count=0, sink_ready=0; sink_ready=1 one cycle after release.
- Normal frame: arm edge, then 256 beats with re=k, im=-2k (k=0..255), sop on bin 0, eop on bin 255 -> done=1 3 cycles after the eop beat, bin_count=256, frame_err=0. Reading rd_index=10 gives rd_data=25 one cycle after the index is applied; rd_index=255 gives 637.
- Saturation/sign: single beat re=-32768, im=-32768 stored at bin 0 -> bin 0 reads 49150; re=0, im=-1 -> reads 1.
- Pre-arm and unframed beats: a frame sent before arm is ignored (done=0, bin_count=0). After arm, 3 beats without sop are discarded, then a sop frame of 16 bins with eop -> bin_count=16.
- Errors: a second sop at bin 5 -> frame_err=1 and the capture restarts at 0. A frame of 300 beats without eop -> frame_err=1, bin_count=256, done=1; beats after the 256th are ignored.
- Arm during CAPTURE at bin 100 -> done=0, bin_count=0, state ARMED; a following 8-bin sop/eop frame gives bin_count=8, frame_err=0. Repeat with reset asserted mid-frame -> all outputs return to reset values asynchronously.
